bus_slave_resp: RTL and testbench



---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_slave_resp_if.sv | 28 ++
 rtl/bus_slave_mem.sv | 43 ++++
 rtl/bus_slave_resp.sv | 129 ++++++++++++
 tb/tb_bus_slave_resp.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared system-bus definitions: address field layout, slave-select codes,
// responder FSM state encoding and a small offset range helper.
// No logic; imported by the responder, its interface and its store.
package bus_pkg;

  localparam int BUS_ADDR_W = 8;

  // Slave-select field driven by the address decoder.
  localparam int SEL_MSB = 6;
  localparam int SEL_LSB = 5;
  localparam logic [1:0] S0   = 2'b00;
  localparam logic [1:0] S1   = 2'b01;
  localparam logic [1:0] NONE = 2'b10;

  // Word offset field inside a slave's window.
  localparam int OFF_MSB = 4;
  localparam int OFF_LSB = 0;
  localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

  // Responder FSM encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_ACK  = ACK
  } state_e;

  // True when a word offset falls outside a store of the given depth.
  function automatic logic off_oor(input logic [OFF_W-1:0] off, input int depth);
    int v;
    v = int'(off);
    return (v >= depth);
  endfunction

endpackage

// File: rtl/bus_slave_resp_if.sv
// Slave-side view of the shared system bus: request, write data and response.
// The master modport drives the request; the slave modport answers it.
// Handshake is request/acknowledge with a one-cycle ack pulse.
interface bus_slave_resp_if #(
  parameter int DATA_W = 32
);

  logic                          s_sel;
  logic                          s_req;
  logic                          s_wr;
  logic [bus_pkg::BUS_ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_ack;
  logic                          s_err;
  logic                          s_busy;

  modport master (
    output s_sel, s_req, s_wr, s_addr, s_wdata,
    input  s_rdata, s_ack, s_err, s_busy
  );

  modport slave (
    input  s_sel, s_req, s_wr, s_addr, s_wdata,
    output s_rdata, s_ack, s_err, s_busy
  );

endinterface

// File: rtl/bus_slave_mem.sv
// Word-addressed register store behind the bus responder.
// Write lands at the clock edge; read data is registered (one cycle).
// No backpressure: every enabled access completes in the cycle it is issued.
module bus_slave_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic              i_rd_zero,
  output logic [DATA_W-1:0] o_rd_dat
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_dat;

  // Storage array and read register; reset clears every word and the read data.
  // An out-of-range read loads zero instead of touching the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_dat <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_idx] <= i_wr_dat;
      end
      if (i_rd_en) begin
        r_rd_dat <= i_rd_zero ? '0 : r_mem[i_rd_idx];
      end
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/bus_slave_resp.sv
// Bus slave responder: captures a selected request, waits WAIT_CYCLES, acks once.
// Latency: request sampled at end of cycle 0 -> s_ack in cycle WAIT_CYCLES+1.
// No new request is taken while busy; the next one is sampled the cycle after ACK.
module bus_slave_resp
  import bus_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  bus_slave_resp_if.slave   bus
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e              r_state;
  state_e              w_next;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic                r_oor;
  logic [OFF_W-1:0]    r_off;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_start;
  logic [OFF_W-1:0]    w_off_in;
  logic                w_oor_in;
  logic                w_rd_en;
  logic [IDX_W-1:0]    w_rd_idx;
  logic                w_rd_zero;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_rd_dat;

  assign w_off_in = bus.s_addr[OFF_MSB:OFF_LSB];
  assign w_oor_in = off_oor(w_off_in, DEPTH);
  assign w_start  = (r_state == ST_IDLE) && bus.s_sel && bus.s_req;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: IDLE -> (WAIT) -> ACK -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_ACK;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture and wait counter; bus inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
    end else begin
      if (w_start) begin
        r_wr    <= bus.s_wr;
        r_oor   <= w_oor_in;
        r_off   <= w_off_in;
        r_wdata <= bus.s_wdata;
        r_cnt   <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Read issue on the edge that enters ACK; with no wait states that edge is
  // also the capture edge, so the live bus offset is used instead of the latch.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_idx  = r_off[IDX_W-1:0];
    w_rd_zero = r_oor;
    if ((WAIT_CYCLES == 0) && w_start && !bus.s_wr) begin
      w_rd_en   = 1'b1;
      w_rd_idx  = w_off_in[IDX_W-1:0];
      w_rd_zero = w_oor_in;
    end else if ((r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_wr) begin
      w_rd_en   = 1'b1;
    end
  end

  // Writes commit at the edge that ends ACK, and only for in-range offsets.
  assign w_wr_en = (r_state == ST_ACK) && r_wr && !r_oor;

  bus_slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_off[IDX_W-1:0]),
    .i_wr_dat  (r_wdata),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .i_rd_zero (w_rd_zero),
    .o_rd_dat  (w_rd_dat)
  );

  // All outputs decode registered state only.
  assign bus.s_rdata = w_rd_dat;
  assign bus.s_ack   = (r_state == ST_ACK);
  assign bus.s_err   = (r_state == ST_ACK) && r_oor;
  assign bus.s_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_slave_resp.sv
// Scoreboarded bench for bus_slave_resp: one instance with two wait states and
// a 16-word store, one with no wait states and a full 32-word store.
module tb_bus_slave_resp;

  logic clk;
  logic reset;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LAT_A = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] m_a [16];
  logic [31:0] m_b [32];
  logic [31:0] last_a;
  logic [31:0] last_b;

  bus_slave_resp_if #(.DATA_W(32)) bus_a ();
  bus_slave_resp_if #(.DATA_W(32)) bus_b ();

  bus_slave_resp #(.DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  bus_slave_resp #(.DATA_W(32), .DEPTH(32), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear;
    for (int i = 0; i < 16; i++) m_a[i] = '0;
    for (int i = 0; i < 32; i++) m_b[i] = '0;
    last_a = '0;
    last_b = '0;
  endtask

  // Expected response of the 16-deep instance for one request.
  task automatic push_a(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [4:0] off;
    off   = addr[4:0];
    e.err = (off >= 5'd16);
    if (!wr) last_a = e.err ? 32'd0 : m_a[off[3:0]];
    else if (!e.err) m_a[off[3:0]] = wd;
    e.rdata = last_a;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    exp_t e;
    e.err = 1'b0;
    if (!wr) last_b = m_b[addr[4:0]];
    else m_b[addr[4:0]] = wd;
    e.rdata = last_b;
    q_b.push_back(e);
  endtask

  // One transaction on instance A; the request is dropped and the bus is
  // scrambled after the capture cycle to show the latched values are used.
  task automatic a_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    int   lat;
    logic got;
    exp_t e;
    @(negedge clk);
    bus_a.s_sel = 1'b1; bus_a.s_req = 1'b1; bus_a.s_wr = wr;
    bus_a.s_addr = addr; bus_a.s_wdata = wd;
    push_a(wr, addr, wd);
    @(posedge clk);
    @(negedge clk);
    bus_a.s_sel = 1'b0; bus_a.s_req = 1'b0; bus_a.s_wr = ~wr;
    bus_a.s_addr = addr ^ 8'h0B; bus_a.s_wdata = ~wd;
    lat = 1;
    got = 1'b0;
    while (lat <= 20 && !got) begin
      if (bus_a.s_ack) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL a_ack_timeout addr=%0d: no ack within 20 cycles", addr);
      return;
    end
    if (lat !== LAT_A) begin
      n_fail++;
      $display("FAIL a_latency addr=%0d: got %0d want %0d", addr, lat, LAT_A);
    end
    n_cmp++;
    if (q_a.size() == 0) begin
      n_fail++;
      $display("FAIL a_scoreboard: ack with empty queue");
      return;
    end
    e = q_a.pop_front();
    n_cmp++;
    if (bus_a.s_err !== e.err) begin
      n_fail++;
      $display("FAIL a_err addr=%0d: got %b want %b", addr, bus_a.s_err, e.err);
    end
    n_cmp++;
    if (bus_a.s_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL a_rdata addr=%0d wr=%b: got %h want %h", addr, wr, bus_a.s_rdata, e.rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_a.s_ack !== 1'b0 || bus_a.s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL a_ack_pulse addr=%0d: ack=%b busy=%b want 0 0", addr, bus_a.s_ack, bus_a.s_busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_a.s_sel = 0; bus_a.s_req = 0; bus_a.s_wr = 0; bus_a.s_addr = 0; bus_a.s_wdata = 0;
    bus_b.s_sel = 0; bus_b.s_req = 0; bus_b.s_wr = 0; bus_b.s_addr = 0; bus_b.s_wdata = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus_a.s_ack, bus_a.s_err, bus_a.s_busy} !== 3'b000 || bus_a.s_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_a: ack/err/busy=%b%b%b rdata=%h want 000 0",
               bus_a.s_ack, bus_a.s_err, bus_a.s_busy, bus_a.s_rdata);
    end
    n_cmp++;
    if ({bus_b.s_ack, bus_b.s_err, bus_b.s_busy} !== 3'b000 || bus_b.s_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_b: ack/err/busy=%b%b%b rdata=%h want 000 0",
               bus_b.s_ack, bus_b.s_err, bus_b.s_busy, bus_b.s_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_nosel;
    @(negedge clk);
    bus_a.s_req = 1'b1; bus_a.s_sel = 1'b0;
    bus_b.s_req = 1'b1; bus_b.s_sel = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_a.s_ack !== 1'b0 || bus_a.s_busy !== 1'b0 || bus_a.s_rdata !== 32'd0 ||
          bus_b.s_ack !== 1'b0 || bus_b.s_busy !== 1'b0 || bus_b.s_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL idle_nosel c=%0d: a ack/busy=%b%b b ack/busy=%b%b want 0",
                 c, bus_a.s_ack, bus_a.s_busy, bus_b.s_ack, bus_b.s_busy);
      end
    end
    bus_a.s_req = 1'b0;
    bus_b.s_req = 1'b0;
  endtask

  task automatic test_rw_wait2;
    a_txn(1'b1, 8'd5, 32'hDEADBEEF);
    a_txn(1'b0, 8'd5, 32'h0);
  endtask

  // Instance B with request held high; the next request is presented while
  // each ack is visible, giving one ack every second cycle.
  task automatic test_stream_wait0;
    logic        t_wr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  t_ad [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    logic [31:0] t_wd [6] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    int   idx, done, last_c;
    exp_t e;
    @(negedge clk);
    bus_b.s_sel = 1'b1; bus_b.s_req = 1'b1;
    bus_b.s_wr = t_wr[0]; bus_b.s_addr = t_ad[0]; bus_b.s_wdata = t_wd[0];
    push_b(t_wr[0], t_ad[0], t_wd[0]);
    idx = 1; done = 0; last_c = -1;
    for (int c = 0; c < 40 && done < 6; c++) begin
      @(negedge clk);
      if (bus_b.s_ack) begin
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          n_cmp++;
          if (bus_b.s_err !== e.err || bus_b.s_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL b_stream_resp #%0d: err=%b rdata=%h want err=%b rdata=%h",
                     done, bus_b.s_err, bus_b.s_rdata, e.err, e.rdata);
          end
        end
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c != 2) begin
            n_fail++;
            $display("FAIL b_stream_gap #%0d: got %0d cycles want 2", done, c - last_c);
          end
        end
        last_c = c;
        done++;
        if (idx < 6) begin
          bus_b.s_wr = t_wr[idx]; bus_b.s_addr = t_ad[idx]; bus_b.s_wdata = t_wd[idx];
          push_b(t_wr[idx], t_ad[idx], t_wd[idx]);
          idx++;
        end else begin
          bus_b.s_sel = 1'b0; bus_b.s_req = 1'b0;
        end
      end
    end
    n_cmp++;
    if (done != 6) begin
      n_fail++;
      $display("FAIL b_stream_count: got %0d acks want 6", done);
      bus_b.s_sel = 1'b0; bus_b.s_req = 1'b0;
    end
  endtask

  task automatic test_out_of_range;
    a_txn(1'b1, 8'd4,  32'hA5A50004);
    a_txn(1'b1, 8'd20, 32'h000000FF);
    a_txn(1'b0, 8'd20, 32'h0);
    a_txn(1'b0, 8'd4,  32'h0);
  endtask

  task automatic test_req_drop;
    a_txn(1'b1, 8'd9, 32'h12345678);
    a_txn(1'b0, 8'd9, 32'h0);
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    bus_a.s_sel = 1'b1; bus_a.s_req = 1'b1; bus_a.s_wr = 1'b1;
    bus_a.s_addr = 8'd7; bus_a.s_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus_a.s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_c1: got %b want 1", bus_a.s_busy);
    end
    reset = 1'b1;
    bus_a.s_sel = 1'b0; bus_a.s_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus_a.s_busy !== 1'b0 || bus_a.s_ack !== 1'b0 || bus_a.s_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_c2: busy=%b ack=%b rdata=%h want 0 0 0",
               bus_a.s_busy, bus_a.s_ack, bus_a.s_rdata);
    end
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_a.s_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_no_ack c=%0d: got %b want 0", c, bus_a.s_ack);
      end
    end
    for (int i = 0; i < 16; i++) begin
      a_txn(1'b0, 8'(i), 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_nosel();
    test_rw_wait2();
    test_stream_wait0();
    test_out_of_range();
    test_req_drop();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
